// File: rtl/oka_seq_pkg.sv
// Shared types and GF(2)[x] helpers for the sequential overlap-free Karatsuba multiplier.
package oka_seq_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        MID,
        HI,
        RED,
        DONE
    } state_e;

    // Plain schoolbook carry-less product of the low n bits of a and b.
    function automatic logic [2*MAX_W-2:0] clmul(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input int n);
        logic [2*MAX_W-2:0] r;
        r = '0;
        for (int j = 0; j < n; j++) begin
            for (int i = 0; i < n; i++) begin
                if (a[i] && b[j]) r[i+j] = ~r[i+j];
            end
        end
        return r;
    endfunction

    // Karatsuba recombination: z1 holds (al^ah)(bl^bh), so the middle term is z0^z1^z2.
    function automatic logic [2*MAX_W-2:0] oka_recombine(input logic [MAX_W-2:0] z0,
                                                         input logic [MAX_W-2:0] z1,
                                                         input logic [MAX_W-2:0] z2,
                                                         input int h);
        logic [2*MAX_W-2:0] e_lo, e_mid, e_hi;
        e_lo  = (2*MAX_W-1)'(z0);
        e_mid = (2*MAX_W-1)'(z0 ^ z1 ^ z2);
        e_hi  = (2*MAX_W-1)'(z2);
        return (e_hi << (2 * h)) ^ (e_mid << h) ^ e_lo;
    endfunction

endpackage

// File: rtl/oka_clmul_core.sv
// Combinational H x H carry-less schoolbook multiplier; shared across the LO/MID/HI steps.
module oka_clmul_core #(
    parameter int H = 16
) (
    input  logic [H-1:0]   a_i,
    input  logic [H-1:0]   b_i,
    output logic [2*H-2:0] p_o
);

    always_comb begin
        p_o = '0;
        for (int i = 0; i < H; i++) begin
            if (b_i[i]) p_o[i +: H] = p_o[i +: H] ^ a_i;
        end
    end

endmodule

// File: rtl/oka_seq_mul.sv
// Iterative overlap-free Karatsuba multiplier over GF(2)[x] with valid/ready handshakes.
// Define OKA_SEQ_REDUCE_EN to add a RED step that reduces the product modulo POLY.
module oka_seq_mul
    import oka_seq_pkg::*;
#(
    parameter int              WIDTH = 32,
    parameter logic [WIDTH:0]  POLY  = (WIDTH+1)'(33'h1_0000_008D)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-2:0] y
);

    localparam int H  = WIDTH / 2;
    localparam int PW = 2 * WIDTH - 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > MAX_W || POLY[WIDTH] != 1'b1) begin : g_bad_param
        $error("oka_seq_mul: WIDTH must be even and 4..%0d, POLY must have degree WIDTH", MAX_W);
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [2*H-2:0]   z0_q, z0_d, z1_q, z1_d;
    logic [PW-1:0]    y_q, y_d;
    logic [H-1:0]     core_a, core_b;
    logic [2*H-2:0]   core_p;

    // The single core sees the low halves, their XOR, or the high halves depending on the step.
    always_comb begin
        core_a = a_q[H-1:0];
        core_b = b_q[H-1:0];
        unique case (state_q)
            MID: begin
                core_a = a_q[H-1:0] ^ a_q[WIDTH-1:H];
                core_b = b_q[H-1:0] ^ b_q[WIDTH-1:H];
            end
            HI: begin
                core_a = a_q[WIDTH-1:H];
                core_b = b_q[WIDTH-1:H];
            end
            default: ;
        endcase
    end

    oka_clmul_core #(.H(H)) u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

`ifdef OKA_SEQ_REDUCE_EN
    // Folding from the top down clears every bit >= WIDTH, so the upper part ends up zero.
    logic [PW-1:0] fold;
    always_comb begin
        fold = y_q;
        for (int i = PW - 1; i >= WIDTH; i--) begin
            if (fold[i]) fold[i-WIDTH +: WIDTH+1] = fold[i-WIDTH +: WIDTH+1] ^ POLY;
        end
    end
`endif

    always_comb begin
        // NOTE: every next-state signal starts from its held value, so no branch can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        z0_d    = z0_q;
        z1_d    = z1_q;
        y_d     = y_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    state_d = LO;
                end
            end
            LO: begin
                z0_d    = core_p;
                state_d = MID;
            end
            MID: begin
                z1_d    = core_p;
                state_d = HI;
            end
            HI: begin
                y_d = PW'(oka_recombine((MAX_W-1)'(z0_q), (MAX_W-1)'(z1_q),
                                        (MAX_W-1)'(core_p), H));
`ifdef OKA_SEQ_REDUCE_EN
                state_d = RED;
`else
                state_d = DONE;
`endif
            end
`ifdef OKA_SEQ_REDUCE_EN
            RED: begin
                y_d     = fold;
                state_d = DONE;
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: flops use non-blocking assignments so each one samples the pre-edge value of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            z0_q    <= '0;
            z1_q    <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            z0_q    <= z0_d;
            z1_q    <= z1_d;
            y_q     <= y_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign y         = y_q;

endmodule

// File: tb/tb_oka_seq_mul.sv
// Self-checking bench: directed handshake/reset cases at WIDTH=32, random traffic at 8/32/64.
module tb_oka_seq_mul;
    import oka_seq_pkg::*;

`ifdef OKA_SEQ_REDUCE_EN
    localparam bit RED_BUILD = 1'b1;
`else
    localparam bit RED_BUILD = 1'b0;
`endif
    localparam int          LAT       = RED_BUILD ? 5 : 4;
    localparam int          N_RAND    = 3000;
    localparam int          CYC_LIMIT = 60000;
    localparam logic [64:0] POLY32    = 65'h1_0000_008D;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic [62:0] y;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Product over GF(2), optionally reduced by polynomial long division.
    function automatic logic [127:0] ref_y(input logic [63:0] ta, input logic [63:0] tb,
                                           input int w, input logic [64:0] poly);
        logic [127:0] p;
        p = 128'(clmul(ta, tb, w));
        if (RED_BUILD) begin
            for (int i = 2 * w - 2; i >= w; i--) begin
                if (p[i]) p = p ^ (128'(poly) << (i - w));
            end
        end
        return p;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    oka_seq_mul #(.WIDTH(32)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    // Offers one pair, then counts cycles (after the accept cycle) until out_valid is seen.
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input logic rdy,
                         output int lat, output int busy);
        @(negedge clk);
        in_valid  = 1'b1;
        a         = ta;
        b         = tb;
        out_ready = rdy;
        #1;
        check("accept_ready", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        lat      = 1;
        busy     = in_ready ? 0 : 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (!in_ready) busy++;
        end
    endtask

    int          lat, busy;
    logic [62:0] held_y;
    bit          stable;

    initial begin : directed
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_y", 128'(y), 128'(0));
        rst = 1'b0;

        do_op(32'h3, 32'h3, 1'b1, lat, busy);
        check("small_latency", 128'(lat), 128'(LAT));
        check("small_busy_cycles", 128'(busy), 128'(LAT));
        check("small_y", 128'(y), 128'h5);
        @(posedge clk);
        #1;
        check("small_valid_drop", 128'(out_valid), 128'(0));
        check("small_ready_back", 128'(in_ready), 128'(1));

        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, busy);
        check("ones_latency", 128'(lat), 128'(LAT));
        check("ones_y", 128'(y), RED_BUILD ? ref_y(64'hFFFF_FFFF, 64'hFFFF_FFFF, 32, POLY32)
                                           : 128'h5555_5555_5555_5555);
        held_y = y;
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || y !== held_y) stable = 1'b0;
        end
        check("backpressure_hold", 128'(stable), 128'(1));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_valid_drop", 128'(out_valid), 128'(0));
        check("release_ready_back", 128'(in_ready), 128'(1));

        do_op(32'h8000_0000, 32'h8000_0000, 1'b1, lat, busy);
        check("top_bit_y", 128'(y), RED_BUILD ? ref_y(64'h8000_0000, 64'h8000_0000, 32, POLY32)
                                              : 128'h4000_0000_0000_0000);
        @(posedge clk);
        #1;

        // Abort an operation while it sits in MID.
        @(negedge clk);
        in_valid  = 1'b1;
        a         = 32'hCAFE_F00D;
        b         = 32'h1357_9BDF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_y", 128'(y), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));

        do_op(32'h1234, 32'h1, 1'b1, lat, busy);
        check("after_rst_latency", 128'(lat), 128'(LAT));
        check("after_rst_y", 128'(y), 128'h1234);
        @(posedge clk);
        #1;

        if (RED_BUILD) begin
            do_op(32'h8000_0000, 32'h2, 1'b1, lat, busy);
            check("red_wrap_y", 128'(y), 128'h8D);
            @(posedge clk);
            #1;
            do_op(32'h1, 32'hDEAD_BEEF, 1'b1, lat, busy);
            check("red_ident_y", 128'(y), 128'hDEAD_BEEF);
            @(posedge clk);
            #1;
        end

        wait (g_rand[0].fin && g_rand[1].fin && g_rand[2].fin);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    for (genvar g = 0; g < 3; g++) begin : g_rand
        localparam int          W    = (g == 0) ? 8 : (g == 1) ? 32 : 64;
        localparam logic [64:0] PALL = (g == 0) ? 65'h11B
                                     : (g == 1) ? 65'h1_0000_008D
                                     :            65'h1_0000_0000_0000_001B;

        logic           r_rst, r_iv, r_ir, r_ov, r_or;
        logic [W-1:0]   r_a, r_b;
        logic [2*W-2:0] r_y;
        bit             fin = 1'b0;

        oka_seq_mul #(.WIDTH(W), .POLY(PALL[W:0])) u_rdut (
            .clk       (clk),
            .rst       (r_rst),
            .in_valid  (r_iv),
            .in_ready  (r_ir),
            .a         (r_a),
            .b         (r_b),
            .out_valid (r_ov),
            .out_ready (r_or),
            .y         (r_y)
        );

        initial begin : stim
            logic [W-1:0] ca, cb;
            logic [127:0] q[$];
            bit           have;
            int           gap, sent, got, cyc;
            r_rst = 1'b1;
            r_iv  = 1'b0;
            r_or  = 1'b0;
            r_a   = '0;
            r_b   = '0;
            ca    = '0;
            cb    = '0;
            have  = 1'b0;
            gap   = 0;
            sent  = 0;
            got   = 0;
            cyc   = 0;
            repeat (2) @(negedge clk);
            r_rst = 1'b0;
            while (got < N_RAND && cyc < CYC_LIMIT) begin
                @(negedge clk);
                cyc++;
                if (!have && sent < N_RAND) begin
                    if (gap > 0) gap--;
                    else begin
                        ca   = W'({$urandom, $urandom});
                        cb   = W'({$urandom, $urandom});
                        have = 1'b1;
                        gap  = $urandom_range(0, 3);
                    end
                end
                r_iv = have;
                r_a  = have ? ca : W'({$urandom, $urandom});
                r_b  = have ? cb : W'({$urandom, $urandom});
                r_or = ($urandom_range(0, 3) != 0);
                #1;
                if (r_iv && r_ir) begin
                    q.push_back(ref_y(64'(ca), 64'(cb), W, PALL));
                    have = 1'b0;
                    sent++;
                end
                if (r_ov && r_or) begin
                    check($sformatf("rand_w%0d_pending", W), 128'(q.size() != 0), 128'(1));
                    if (q.size() != 0) check($sformatf("rand_w%0d_y", W), 128'(r_y), q.pop_front());
                    got++;
                end
            end
            check($sformatf("rand_w%0d_count", W), 128'(got), 128'(N_RAND));
            fin = 1'b1;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: run did not complete, got %0d vectors", n_vec);
        $fatal(1);
    end

endmodule
